// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared types and constants for the HDMI output path
package hdmi_pkg;
  localparam int RGB_W = 24;
  localparam logic SRC_CBAR = 1'b0;
  localparam logic SRC_ISP = 1'b1;
  typedef enum logic [1:0] {WAIT_LOCK, CBAR, ISP} sched_state_t;
endpackage

// File: rtl/lock_debounce.sv
// lock_debounce: counts consecutive locked cycles and flags a lock that has been stable LOCK_WAIT cycles
module lock_debounce #(
  parameter int LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic locked_i,
  output logic locked_stable_o
);
  localparam int CW = $clog2(LOCK_WAIT);
  localparam logic [CW-1:0] LAST = CW'(LOCK_WAIT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = !locked_i ? '0 : (cnt_q == LAST ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign locked_stable_o = locked_i && cnt_q == LAST;
endmodule

// File: rtl/hdmi_source_sched.sv
// hdmi_source_sched: lock-gated, frame-synchronous source select between colour bars and ISP,
// with underflow fill and sticky fallback to colour bars after repeated bad ISP frames
module hdmi_source_sched
  import hdmi_pkg::*;
#(
  parameter int LOCK_WAIT = 1024,
  parameter int BAD_FRAME_LIMIT = 4,
  parameter logic [RGB_W-1:0] FILL_COLOR = 24'h000000
) (
  input  logic pixel_clk,
  input  logic sys_rst,
  input  logic clk_locked,
  input  logic sel_req,
  input  logic frame_start,
  input  logic pixel_req,
  input  logic [RGB_W-1:0] cbar_data,
  input  logic [RGB_W-1:0] isp_data,
  input  logic isp_valid,
  output logic isp_ready,
  output logic [RGB_W-1:0] pixel_data,
  output logic timing_en,
  output logic active_src,
  output logic fallback,
  output logic [15:0] underflow_cnt
);
  localparam logic [3:0] BAD_LIM = 4'(BAD_FRAME_LIMIT);
  sched_state_t state_q, state_d;
  logic [3:0] bad_q, bad_d, bad_inc;
  logic fuf_q, fuf_d, fb_q, fb_d, ten_q, asrc_q, lock_ok, uf, frame_bad;
  logic [RGB_W-1:0] pix_q, pix_d;
  logic [15:0] ucnt_q, ucnt_d;

  lock_debounce #(.LOCK_WAIT(LOCK_WAIT)) u_lock (
    .clk(pixel_clk),
    .rst(sys_rst),
    .locked_i(clk_locked),
    .locked_stable_o(lock_ok)
  );

  assign isp_ready = pixel_req && isp_valid && state_q == ISP;
  assign uf = pixel_req && !isp_valid && state_q == ISP;
  // a pixel served in the frame_start cycle still belongs to the ending frame
  assign frame_bad = fuf_q || uf;
  assign bad_inc = bad_q + 1'b1;

  always_comb begin
    state_d = state_q;
    bad_d = bad_q;
    fb_d = fb_q && sel_req;
    fuf_d = frame_start ? 1'b0 : frame_bad;
    ucnt_d = (uf && ucnt_q != 16'hFFFF) ? ucnt_q + 1'b1 : ucnt_q;
    pix_d = (!clk_locked || !pixel_req) ? '0 :
            state_q == CBAR ? cbar_data :
            state_q == ISP ? (isp_valid ? isp_data : FILL_COLOR) : '0;
    if (!clk_locked) begin
      state_d = WAIT_LOCK;
      bad_d = '0;
    end else if (state_q == WAIT_LOCK) begin
      if (lock_ok) state_d = CBAR;
    end else if (frame_start) begin
      if (state_q == CBAR) begin
        if (sel_req && !fb_q) begin
          state_d = ISP;
          bad_d = '0;
          ucnt_d = '0;
        end
      end else if (!sel_req) state_d = CBAR;
      else if (!frame_bad) bad_d = '0;
      else begin
        bad_d = bad_inc;
        if (bad_inc == BAD_LIM) begin
          state_d = CBAR;
          fb_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q <= WAIT_LOCK;
      bad_q <= '0;
      fuf_q <= 1'b0;
      fb_q <= 1'b0;
      ucnt_q <= '0;
      pix_q <= '0;
      ten_q <= 1'b0;
      asrc_q <= SRC_CBAR;
    end else begin
      state_q <= state_d;
      bad_q <= bad_d;
      fuf_q <= fuf_d;
      fb_q <= fb_d;
      ucnt_q <= ucnt_d;
      pix_q <= pix_d;
      ten_q <= state_d != WAIT_LOCK;
      asrc_q <= state_d == ISP ? SRC_ISP : SRC_CBAR;
    end
  end

  assign pixel_data = pix_q;
  assign timing_en = ten_q;
  assign active_src = asrc_q;
  assign fallback = fb_q;
  assign underflow_cnt = ucnt_q;
endmodule

// File: tb/tb_hdmi_source_sched.sv
// tb_hdmi_source_sched: directed scenarios plus randomized traffic against a mode-level reference model
module tb_hdmi_source_sched;
  localparam int LOCK_WAIT = 1024;
  localparam int BAD_LIMIT = 4;
  localparam logic [23:0] FILL = 24'h10EB80;

  logic clk = 1'b0;
  logic rst, locked, sel, fs, preq, ival, rdy, ten, asrc, fb;
  logic [23:0] cbar, isp, pix;
  logic [15:0] ucnt;
  int vec = 0, errs = 0;

  // reference model: mode 0 = waiting for lock, 1 = colour bars, 2 = ISP
  int m_md, m_run, m_bad, m_ucnt;
  logic m_fuf, m_fb, m_ten, m_asrc, m_rdy, rdy_seen;
  logic [23:0] m_pix;

  hdmi_source_sched #(.LOCK_WAIT(LOCK_WAIT), .BAD_FRAME_LIMIT(BAD_LIMIT), .FILL_COLOR(FILL)) dut (
    .pixel_clk(clk), .sys_rst(rst), .clk_locked(locked), .sel_req(sel), .frame_start(fs),
    .pixel_req(preq), .cbar_data(cbar), .isp_data(isp), .isp_valid(ival), .isp_ready(rdy),
    .pixel_data(pix), .timing_en(ten), .active_src(asrc), .fallback(fb), .underflow_cnt(ucnt)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    int nm;
    if (rst) begin
      m_md = 0; m_run = 0; m_bad = 0; m_fuf = 0; m_fb = 0; m_ucnt = 0;
      m_pix = '0; m_ten = 0; m_asrc = 0;
    end else begin
      m_run = locked ? m_run + 1 : 0;
      m_pix = '0;
      if (preq && m_md == 2 && !ival) begin
        if (m_ucnt < 65535) m_ucnt++;
        m_fuf = 1;
      end
      if (preq && locked) m_pix = m_md == 1 ? cbar : m_md == 2 ? (ival ? isp : FILL) : 24'h0;
      nm = m_md;
      if (!locked) begin
        nm = 0; m_bad = 0;
      end else if (m_md == 0) begin
        if (m_run >= LOCK_WAIT) nm = 1;
      end else if (fs && m_md == 1) begin
        if (sel && !m_fb) begin nm = 2; m_bad = 0; m_ucnt = 0; end
      end else if (fs) begin
        if (!sel) nm = 1;
        else if (m_fuf) begin
          m_bad++;
          if (m_bad == BAD_LIMIT) begin nm = 1; m_fb = 1; end
        end else m_bad = 0;
      end
      if (fs) m_fuf = 0;
      if (!sel) m_fb = 0;
      m_md = nm;
      m_ten = nm != 0;
      m_asrc = nm == 2;
    end
  endtask

  task automatic step();
    @(negedge clk);
    rdy_seen = rdy;
    m_rdy = preq && ival && m_md == 2;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; locked = 1; sel = 1; fs = 0; preq = 1; ival = 1;
    cbar = 24'($urandom); isp = 24'($urandom);
    repeat (3) step();
    vec++;
    if ({pix, ten, asrc, fb, ucnt, rdy_seen} !== '0) begin
      errs++; $display("FAIL reset got pix=%h ten=%b src=%b fb=%b ucnt=%0d rdy=%b want all 0", pix, ten, asrc, fb, ucnt, rdy_seen);
    end
    rst = 0; locked = 0; sel = 0; preq = 0; ival = 0;
  endtask

  task automatic test_lock();
    repeat (10) step();
    locked = 1;
    for (int i = 0; i < LOCK_WAIT; i++) begin
      step();
      vec++;
      if (ten !== (i == LOCK_WAIT - 1) || ten !== m_ten) begin
        errs++; $display("FAIL lock_rise cyc=%0d got ten=%b want %b", i, ten, i == LOCK_WAIT - 1);
      end
    end
    locked = 0; step(); vec++;
    if (ten !== 1'b0) begin errs++; $display("FAIL lock_loss got ten=%b want 0", ten); end
    locked = 1; repeat (590) step();
    locked = 0; step();
    locked = 1;
    for (int i = 0; i < LOCK_WAIT; i++) begin
      step();
      vec++;
      if (ten !== (i == LOCK_WAIT - 1)) begin
        errs++; $display("FAIL lock_relock cyc=%0d got ten=%b want %b", i, ten, i == LOCK_WAIT - 1);
      end
    end
  endtask

  task automatic test_switch();
    logic [23:0] prev;
    sel = 0; fs = 1; step(); fs = 0;
    for (int i = 0; i < 8; i++) begin
      preq = 1; ival = 1; sel = i >= 3;
      cbar = 24'($urandom); isp = 24'($urandom); prev = cbar;
      step();
      vec++;
      if (pix !== prev || asrc !== 1'b0 || rdy_seen !== 1'b0) begin
        errs++; $display("FAIL switch_mid got pix=%h src=%b rdy=%b want pix=%h src=0 rdy=0", pix, asrc, rdy_seen, prev);
      end
    end
    preq = 0; fs = 1; step(); fs = 0; vec++;
    if (asrc !== 1'b1 || pix !== 24'h0) begin
      errs++; $display("FAIL switch_src got src=%b pix=%h want src=1 pix=000000", asrc, pix);
    end
    preq = 1; ival = 1; isp = 24'hA5A5A5; step(); preq = 0; vec++;
    if (pix !== 24'hA5A5A5 || rdy_seen !== 1'b1) begin
      errs++; $display("FAIL switch_isp got pix=%h rdy=%b want pix=a5a5a5 rdy=1", pix, rdy_seen);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      preq = 1; ival = 0; isp = 24'($urandom); step(); vec++;
      if (pix !== FILL || rdy_seen !== 1'b0) begin
        errs++; $display("FAIL underflow_pix got pix=%h rdy=%b want pix=%h rdy=0", pix, rdy_seen, FILL);
      end
    end
    preq = 0; vec++;
    if (ucnt !== 16'd3) begin errs++; $display("FAIL underflow_cnt got %0d want 3", ucnt); end
  endtask

  task automatic test_fallback();
    for (int k = 1; k <= 4; k++) begin
      fs = 1; step(); fs = 0; vec++;
      if (asrc !== (k < 4) || fb !== (k == 4)) begin
        errs++; $display("FAIL fallback_frame k=%0d got src=%b fb=%b want src=%b fb=%b", k, asrc, fb, k < 4, k == 4);
      end
      if (k < 4) begin
        preq = 1; ival = 0; step();
        ival = 1; isp = 24'($urandom); step(); preq = 0;
      end
    end
    fs = 1; step(); fs = 0; vec++;
    if (asrc !== 1'b0 || fb !== 1'b1) begin
      errs++; $display("FAIL fallback_hold got src=%b fb=%b want src=0 fb=1", asrc, fb);
    end
    sel = 0; step(); sel = 1; step(); vec++;
    if (fb !== 1'b0 || asrc !== 1'b0) begin
      errs++; $display("FAIL fallback_clear got fb=%b src=%b want fb=0 src=0", fb, asrc);
    end
    fs = 1; step(); fs = 0; vec++;
    if (asrc !== 1'b1 || ucnt !== 16'd0) begin
      errs++; $display("FAIL fallback_reenter got src=%b ucnt=%0d want src=1 ucnt=0", asrc, ucnt);
    end
  endtask

  task automatic test_recovery();
    for (int k = 0; k < 7; k++) begin
      if (k != 3) begin preq = 1; ival = 0; step(); end
      preq = 1; ival = 1; isp = 24'($urandom); step(); preq = 0;
      fs = 1; step(); fs = 0; vec++;
      if (fb !== 1'b0 || asrc !== 1'b1) begin
        errs++; $display("FAIL recovery k=%0d got fb=%b src=%b want fb=0 src=1", k, fb, asrc);
      end
    end
  endtask

  task automatic test_collision();
    logic [23:0] x;
    sel = 0; step(); vec++;
    if (asrc !== 1'b1) begin errs++; $display("FAIL coll_ignore got src=%b want 1", asrc); end
    x = 24'($urandom); fs = 1; preq = 1; ival = 1; isp = x; cbar = ~x; step(); fs = 0; vec++;
    if (pix !== x || rdy_seen !== 1'b1 || asrc !== 1'b0) begin
      errs++; $display("FAIL coll_to_bar got pix=%h rdy=%b src=%b want pix=%h rdy=1 src=0", pix, rdy_seen, asrc, x);
    end
    x = 24'($urandom); cbar = x; isp = ~x; step(); vec++;
    if (pix !== x || rdy_seen !== 1'b0) begin
      errs++; $display("FAIL coll_bar_next got pix=%h rdy=%b want pix=%h rdy=0", pix, rdy_seen, x);
    end
    sel = 1; fs = 1; x = 24'($urandom); cbar = x; isp = ~x; step(); fs = 0; vec++;
    if (pix !== x || rdy_seen !== 1'b0 || asrc !== 1'b1) begin
      errs++; $display("FAIL coll_to_isp got pix=%h rdy=%b src=%b want pix=%h rdy=0 src=1", pix, rdy_seen, asrc, x);
    end
    x = 24'($urandom); isp = x; cbar = ~x; step(); preq = 0; vec++;
    if (pix !== x || rdy_seen !== 1'b1) begin
      errs++; $display("FAIL coll_isp_next got pix=%h rdy=%b want pix=%h rdy=1", pix, rdy_seen, x);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5000; i++) begin
      rst = i == 2000;
      locked = 1;
      if ($urandom_range(0, 79) == 0) sel = ~sel;
      fs = $urandom_range(0, 19) == 0;
      preq = $urandom_range(0, 3) != 0;
      ival = $urandom_range(0, 9) != 0;
      cbar = 24'($urandom); isp = 24'($urandom);
      step();
      vec++;
      if ({pix, ten, asrc, fb, ucnt, rdy_seen} !== {m_pix, m_ten, m_asrc, m_fb, 16'(m_ucnt), m_rdy}) begin
        errs++;
        $display("FAIL random cyc=%0d got pix=%h ten=%b src=%b fb=%b ucnt=%0d rdy=%b want pix=%h ten=%b src=%b fb=%b ucnt=%0d rdy=%b",
                 i, pix, ten, asrc, fb, ucnt, rdy_seen, m_pix, m_ten, m_asrc, m_fb, m_ucnt, m_rdy);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_switch();
    test_underflow();
    test_fallback();
    test_recovery();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/hdmi_source_sched.md
# hdmi_source_sched

Frame-synchronous source scheduler for the HDMI output path. It sits between the clock wizard, the video timing driver, the colour-bar generator and the ISP pixel stream, and sequences startup: timing is released only after the PLL lock has been stable. It selects which source feeds the driver's pixel request, switching only on frame boundaries. It also handles ISP underflow by filling with a fixed colour and falling back to colour bars after repeated bad frames.

## Interface

- LOCK_WAIT, 1024: cycles `clk_locked` must stay high before `timing_en` asserts (≥2).
- BAD_FRAME_LIMIT, 4: consecutive ISP frames with underflow that force fallback (1..15).
- FILL_COLOR, 24'h000000: RGB substituted on ISP underflow.

Ports:

- pixel_clk  in  1  pixel clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- clk_locked  in  1  PLL lock, already synchronous to pixel_clk.
- sel_req  in  1  requested source, level: 0 = colour bar, 1 = ISP.
- frame_start  in  1  one-cycle pulse from the timing driver at frame start.
- pixel_req  in  1  driver pixel request; data is due on the next cycle.
- cbar_data  in  24  colour-bar RGB, valid in the `pixel_req` cycle.
- isp_data  in  24  ISP RGB, head of the ISP FIFO (show-ahead).
- isp_valid  in  1  ISP FIFO non-empty.
- isp_ready  out  1  pop strobe to the ISP FIFO; combinational.
- pixel_data  out  24  registered RGB to the driver.
- timing_en  out  1  enables the timing driver and the DVI transmitter.
- active_src  out  1  source currently driving: 0 = bar, 1 = ISP.
- fallback  out  1  sticky: scheduler forced colour bars due to underflow.
- underflow_cnt  out  16  saturating count of underflowed ISP pixels.

## Operation

States: WAIT_LOCK, CBAR, ISP.

- **WAIT_LOCK**
  - The lock counter increments while `clk_locked` is 1 and clears to 0 when it is 0.
  - When the count reaches LOCK_WAIT-1 with `clk_locked` still high, go to CBAR.
- **From any state**
  - `clk_locked` = 0 → go to WAIT_LOCK next cycle.
  - The lock counter, bad-frame counter and `pixel_data` clear.
- **CBAR**
  - On `frame_start`, if `sel_req`=1 and `fallback`=0 → go to ISP.
  - On entry to ISP, `underflow_cnt` and the bad-frame counter clear.
- **ISP**, on `frame_start`:
  - If `sel_req`=0 → go to CBAR.
  - Otherwise, if the ending frame had ≥1 underflow, increment the bad-frame counter; if it now equals BAD_FRAME_LIMIT → go to CBAR and set `fallback`.
  - If the ending frame had no underflow, the bad-frame counter clears.
  - The per-frame underflow flag clears.
- **`fallback`** clears only when `sel_req`=0 (checked every cycle) or on reset. Re-entering ISP therefore requires `sel_req` to toggle.
- **Pixel path**, evaluated in the `pixel_req` cycle:
  - CBAR: `pixel_data` ← `cbar_data`.
  - ISP with `isp_valid`=1: `pixel_data` ← `isp_data`, and `isp_ready`=1.
  - ISP with `isp_valid`=0: `pixel_data` ← FILL_COLOR, `isp_ready`=0, `underflow_cnt` +1 (saturates at 16'hFFFF), and the frame underflow flag is set.
  - No `pixel_req`, or in WAIT_LOCK: `pixel_data` ← 0, `isp_ready`=0.
- **`isp_ready`** = `pixel_req` & `isp_valid` & (state == ISP). It never pops outside ISP.
- **`frame_start` and `pixel_req` in the same cycle:** the pixel is served by the current (pre-transition) state and counts toward the ending frame.
- **Outputs:**
  - `timing_en` = (state != WAIT_LOCK), registered.
  - `active_src` = (state == ISP), registered.

## Timing

- **Reset values:** state WAIT_LOCK; `pixel_data`=0, `timing_en`=0, `active_src`=0, `fallback`=0, `underflow_cnt`=0; all counters 0. `isp_ready` is combinationally 0.
- **Lock latency:** `timing_en` rises LOCK_WAIT cycles after the first cycle of a continuous `clk_locked` high.
- **Lock loss:** `timing_en` falls 1 cycle after `clk_locked` falls.
- **Pixel latency:** exactly 1 cycle from `pixel_req` to `pixel_data`.
- **Source switch:** takes effect on the first `pixel_req` after the cycle following `frame_start`. `active_src` updates 1 cycle after `frame_start`.
- **`sel_req` changes mid-frame** are ignored until the next `frame_start`.
- **Reset mid-frame:** the ISP FIFO is not popped after reset; flushing it is upstream's responsibility.

## Structure

- Shared package `hdmi_pkg`:
  - state enum `sched_state_t` {WAIT_LOCK, CBAR, ISP};
  - `RGB_W` = 24;
  - source encodings `SRC_CBAR` = 0 and `SRC_ISP` = 1.
- Sub-module `lock_debounce` (lock counter plus `locked_stable` output): natural, reusable for other PLL domains.
- Pixel mux and underflow accounting stay in the top.

## Test plan

- **Lock:** `clk_locked` high at cycle 10 → `timing_en`=1 at cycle 10+1024. Drop at cycle 600 and re-raise at 601 → `timing_en` stays 0 until 601+1024.
- **Switch:** `sel_req`=1 asserted mid-frame with `pixel_req` active → `pixel_data` follows `cbar_data` until `frame_start`. The first request after it returns `isp_data` (e.g. 24'hA5A5A5), and `isp_ready` pulses with it.
- **Underflow:** in ISP, `isp_valid`=0 for 3 requests → `pixel_data`=FILL_COLOR three times, `underflow_cnt`=3, `isp_ready` never asserted.
- **Fallback:** 4 consecutive frames each containing one underflow → at the 4th following `frame_start`, `active_src`=0 and `fallback`=1. Holding `sel_req`=1 keeps CBAR. `sel_req`=0 then 1 → ISP after the next `frame_start`.
- **Recovery:** 3 bad frames, 1 clean, 3 bad → no fallback (the counter clears on the clean frame).
- **Collision:** `frame_start` and `pixel_req` in the same cycle with a pending switch → that pixel comes from the old source; the next request comes from the new source.
